// File: rtl/uart_tx_arb.sv
// uart_tx_arb
// -----------------------------------------------------------------------------
// Shares the single byte-wide uart_tx transmitter between the ADC sample
// stream and the command/response byte path. A 12-bit ADC sample is framed
// into a marked two-byte packet (bit 7 set only on the first byte). A command
// is sent as one raw byte. Arbitration is round-robin and happens only between
// packets, so a packet is never interleaved with the other requester's bytes.
// Each byte is launched with a one-cycle start pulse. The arbiter then waits
// for uart_tx_busy to rise, and then to fall, before it moves on.
//
// Optional feature (compile-time macro UART_TX_ARB_CKSUM_EN):
//   When defined, every sample packet carries a third byte
//   {2'b01, s[11:6] ^ s[5:0]}. Command packets are the same in both builds.
//
// Parameters:
//   WAIT_MAX         cycles allowed for uart_tx_busy to rise after a start
//                    pulse before the byte is declared lost (1..255)
//
// Ports:
//   uart_tx_arb_clk  baud clock, same net as the uart_tx bit clock
//   uart_tx_arb_rst  synchronous, active-high reset
//   smp_req/smp_data ADC sample request (held until ack) and 12-bit sample
//   smp_ack          one-cycle pulse when the sample is captured
//   cmd_req/cmd_data command byte request (held until ack) and byte
//   cmd_ack          one-cycle pulse when the command byte is captured
//   uart_tx_start    start pulse to uart_tx
//   uart_tx_data     byte to uart_tx, stable for the whole byte
//   uart_tx_busy     busy flag from uart_tx
//   arb_busy         high whenever a packet is in progress
//   arb_err          sticky busy-timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module uart_tx_arb #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        uart_tx_arb_clk,
  input  logic        uart_tx_arb_rst,
  input  logic        smp_req,
  input  logic [11:0] smp_data,
  output logic        smp_ack,
  input  logic        cmd_req,
  input  logic [7:0]  cmd_data,
  output logic        cmd_ack,
  output logic        uart_tx_start,
  output logic [7:0]  uart_tx_data,
  input  logic        uart_tx_busy,
  output logic        arb_busy,
  output logic        arb_err
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_START     = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  localparam logic GRANT_SMP = 1'b0;
  localparam logic GRANT_CMD = 1'b1;

  localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);

  // Index of the last byte of a sample packet.
`ifdef UART_TX_ARB_CKSUM_EN
  localparam logic [1:0] SMP_LAST_IDX = 2'd2;
`else
  localparam logic [1:0] SMP_LAST_IDX = 2'd1;
`endif

  logic [1:0] state;
  logic       last_grant;
  logic [7:0] byte0;
  logic [7:0] byte1;
`ifdef UART_TX_ARB_CKSUM_EN
  logic [7:0] byte2;
`endif
  logic [1:0] last_idx;
  logic [1:0] idx;
  logic [7:0] wait_cnt;

  logic       grant_smp;
  logic       grant_cmd;
  logic [7:0] cur_byte;

  assign arb_busy = (state != ST_IDLE);

  // Round-robin choice. When both requesters are pending, the one not served
  // last wins. A lone requester always wins.
  always_comb begin
    grant_smp = 1'b0;
    grant_cmd = 1'b0;
    if (smp_req && cmd_req) begin
      if (last_grant == GRANT_CMD) begin
        grant_smp = 1'b1;
      end else begin
        grant_cmd = 1'b1;
      end
    end else if (smp_req) begin
      grant_smp = 1'b1;
    end else if (cmd_req) begin
      grant_cmd = 1'b1;
    end
  end

  // Select the packet byte that the current index points at.
  always_comb begin
    cur_byte = byte0;
    case (idx)
      2'd1:    cur_byte = byte1;
`ifdef UART_TX_ARB_CKSUM_EN
      2'd2:    cur_byte = byte2;
`endif
      default: cur_byte = byte0;
    endcase
  end

  // Packet sequencer. The start pulse and the data byte are registered out of
  // START, so they appear in the cycle after START. The same cycle is the
  // first WAIT_BUSY cycle.
  always_ff @(posedge uart_tx_arb_clk) begin
    if (uart_tx_arb_rst) begin
      state         <= ST_IDLE;
      last_grant    <= GRANT_CMD;
      byte0         <= 8'h00;
      byte1         <= 8'h00;
`ifdef UART_TX_ARB_CKSUM_EN
      byte2         <= 8'h00;
`endif
      last_idx      <= 2'd0;
      idx           <= 2'd0;
      wait_cnt      <= 8'd0;
      smp_ack       <= 1'b0;
      cmd_ack       <= 1'b0;
      uart_tx_start <= 1'b0;
      uart_tx_data  <= 8'h00;
      arb_err       <= 1'b0;
    end else begin
      smp_ack       <= 1'b0;
      cmd_ack       <= 1'b0;
      uart_tx_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_smp) begin
            byte0      <= {2'b10, smp_data[11:6]};
            byte1      <= {2'b00, smp_data[5:0]};
`ifdef UART_TX_ARB_CKSUM_EN
            byte2      <= {2'b01, smp_data[11:6] ^ smp_data[5:0]};
`endif
            last_idx   <= SMP_LAST_IDX;
            smp_ack    <= 1'b1;
            last_grant <= GRANT_SMP;
            idx        <= 2'd0;
            state      <= ST_START;
          end else if (grant_cmd) begin
            byte0      <= cmd_data;
            last_idx   <= 2'd0;
            cmd_ack    <= 1'b1;
            last_grant <= GRANT_CMD;
            idx        <= 2'd0;
            state      <= ST_START;
          end
        end

        ST_START: begin
          uart_tx_start <= 1'b1;
          uart_tx_data  <= cur_byte;
          wait_cnt      <= 8'd0;
          state         <= ST_WAIT_BUSY;
        end

        // Busy takes priority over the timeout. If busy rises in the cycle
        // the counter reaches its limit, the byte still counts as accepted.
        ST_WAIT_BUSY: begin
          if (uart_tx_busy) begin
            state <= ST_WAIT_DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (wait_cnt == WAIT_LIMIT - 8'd1) begin
              arb_err <= 1'b1;
              state   <= ST_IDLE;
            end
          end
        end

        ST_WAIT_DONE: begin
          if (!uart_tx_busy) begin
            if (idx != last_idx) begin
              idx   <= idx + 2'd1;
              state <= ST_START;
            end else begin
              state <= ST_IDLE;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
